pipe_stage_regs: RTL and testbench
==================================

Name: pipe_stage_regs

Overview:
- Pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB) for the 5-stage RV32I core.
- Consumes the per-stage stall and flush controls produced by the hazard detection unit.
- Feeds stage instructions back to the hazard detection unit.
- Carries pc, instr and a valid bit per stage, inserts NOP bubbles on flush, and keeps stall, flush and retire performance counters.

Parameters:
XLEN, 32, pc/instr width
CNT_W, 32, performance counter width
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0; rd=0 so it never raises a data hazard)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high, whole-block reset
i_pc_if  in  XLEN  fetch pc
i_instr_if  in  XLEN  fetched instruction
i_reset_if  in  1  active-low synchronous clear of IF/ID
i_reset_id  in  1  active-low synchronous clear of ID/EX
i_reset_ex  in  1  active-low synchronous clear of EX/MEM
i_reset_mem  in  1  active-low synchronous clear of MEM/WB
i_enable_if  in  1  load enable IF/ID
i_enable_id  in  1  load enable ID/EX
i_enable_ex  in  1  load enable EX/MEM
i_enable_mem  in  1  load enable MEM/WB
i_cnt_clr  in  1  synchronous clear of all counters
o_pc_id, o_instr_id, o_valid_id  out  XLEN/XLEN/1  IF/ID contents
o_pc_ex, o_instr_ex, o_valid_ex  out  XLEN/XLEN/1  ID/EX contents
o_pc_mem, o_instr_mem, o_valid_mem  out  XLEN/XLEN/1  EX/MEM contents
o_pc_wb, o_instr_wb, o_valid_wb  out  XLEN/XLEN/1  MEM/WB contents
o_stall_cnt  out  CNT_W  cycles IF/ID was held
o_flush_cnt  out  CNT_W  valid entries discarded by clears
o_retire_cnt  out  CNT_W  valid instructions entering WB

Behaviour:
- Reset (i_reset=1, async):
  - Every stage register: pc=0, instr=NOP_INSTR, valid=0.
  - All counters = 0.
  - Outputs take these values immediately, independent of i_clk.
- Each register R_k loads from its upstream source S_k on every rising edge. Sources:
  - IF/ID: {i_pc_if, i_instr_if, valid=1}.
  - ID/EX, EX/MEM, MEM/WB: the previous register's contents.
- Per-register priority, applied identically to all four registers:
  1. clear low: load bubble {0, NOP_INSTR, 0}. Clear wins over a low enable.
  2. else enable high: load S_k.
  3. else: hold R_k.
- Latency: one cycle per stage. An instruction presented at IF appears in o_*_wb four edges later with no stalls.
- Data-hazard pattern (IF/ID hold + ID/EX clear): IF/ID holds, a bubble enters EX, EX/MEM and MEM/WB advance. The held instruction re-enters ID/EX on the first edge after the hazard clears.
- Control-flush pattern (clears on IF/ID, ID/EX, EX/MEM): all three become bubbles on the same edge. MEM/WB still advances.
- Counters, all wrap modulo 2^CNT_W:
  - o_stall_cnt: +1 on each edge where i_enable_if=0 and i_reset_if=1.
  - o_flush_cnt: + (number of registers whose clear is low AND whose current valid=1). Adds 0..4 in one cycle.
  - o_retire_cnt: +1 on each edge where MEM/WB loads S_k with o_valid_mem=1 (i_enable_mem=1, i_reset_mem=1). A held MEM/WB is not recounted.
  - i_cnt_clr=1: all counters load 0 on that edge, overriding any increment in the same cycle.
  - i_reset overrides everything.
- Async reset asserted mid-operation discards all in-flight entries. The first edge after deassertion loads IF/ID normally.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package pipe_pkg:
  - localparam NOP_INSTR.
  - typedef struct packed stage_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr; logic valid;}.
  - function bubble() returning the reset/bubble stage_t.
- Sub-module pipe_stage_reg (ports i_clk, i_reset, i_clr_n, i_en, i_d stage_t, o_q stage_t) implements the reset/clear/enable/hold priority. Instantiated four times.
- Counters live in the top module.

Test Plan:
- Reset then free-flow: pcs 0x00,0x04,0x08,0x0C with all enables 1 and clears 1 -> o_pc_wb=0x00 on edge 4, then 0x04, 0x08, 0x0C on successive edges; retire_cnt=4 after edge 7.
- Data-hazard stall: hold i_enable_if=0, i_reset_id=0 for 1 cycle with instr 0x00208133 in IF/ID -> IF/ID unchanged; o_instr_ex=0x00000013, o_valid_ex=0; stall_cnt=1; 0x00208133 reaches EX the next edge.
- Control flush: all three stages valid; pulse i_reset_if/id/ex=0 for 1 cycle -> IF/ID, ID/EX, EX/MEM become bubbles; MEM/WB takes the old EX/MEM entry; flush_cnt += 3.
- Clear with enable low: i_enable_mem=0, i_reset_mem=0, o_valid_wb=1 -> MEM/WB becomes a bubble; flush_cnt += 1; retire_cnt unchanged.
- Counter wrap and clear: CNT_W=4, 16 stall cycles -> stall_cnt wraps to 0. i_cnt_clr together with a stall -> stall_cnt=0.
- Async reset mid-flight: assert i_reset between edges with 4 valid stages -> all valid=0 and instr=0x00000013 before the next edge; counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline register bank.
package pipe_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   // One pipeline stage slot: program counter, instruction word, valid flag.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            valid;
   } stage_t;

   // Empty slot used for reset and for squashed stages; rd=0 so it never
   // looks like a producer to the hazard unit.
   function automatic stage_t bubble();
      stage_t b;
      b.pc    = '0;
      b.instr = NOP_INSTR;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Control/data bundle between the fetch/hazard logic and the pipeline register bank.
interface pipe_stage_regs_if #(
   parameter int CNT_W = 32
);
   import pipe_pkg::*;

   logic [XLEN-1:0]  i_pc_if;
   logic [XLEN-1:0]  i_instr_if;
   logic             i_reset_if;
   logic             i_reset_id;
   logic             i_reset_ex;
   logic             i_reset_mem;
   logic             i_enable_if;
   logic             i_enable_id;
   logic             i_enable_ex;
   logic             i_enable_mem;
   logic             i_cnt_clr;

   logic [XLEN-1:0]  o_pc_id;
   logic [XLEN-1:0]  o_instr_id;
   logic             o_valid_id;
   logic [XLEN-1:0]  o_pc_ex;
   logic [XLEN-1:0]  o_instr_ex;
   logic             o_valid_ex;
   logic [XLEN-1:0]  o_pc_mem;
   logic [XLEN-1:0]  o_instr_mem;
   logic             o_valid_mem;
   logic [XLEN-1:0]  o_pc_wb;
   logic [XLEN-1:0]  o_instr_wb;
   logic             o_valid_wb;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;
   logic [CNT_W-1:0] o_retire_cnt;

   // Fetch/hazard side: drives controls, observes stage contents.
   modport master (
      output i_pc_if, i_instr_if,
      output i_reset_if, i_reset_id, i_reset_ex, i_reset_mem,
      output i_enable_if, i_enable_id, i_enable_ex, i_enable_mem,
      output i_cnt_clr,
      input  o_pc_id, o_instr_id, o_valid_id,
      input  o_pc_ex, o_instr_ex, o_valid_ex,
      input  o_pc_mem, o_instr_mem, o_valid_mem,
      input  o_pc_wb, o_instr_wb, o_valid_wb,
      input  o_stall_cnt, o_flush_cnt, o_retire_cnt
   );

   // Register bank side.
   modport slave (
      input  i_pc_if, i_instr_if,
      input  i_reset_if, i_reset_id, i_reset_ex, i_reset_mem,
      input  i_enable_if, i_enable_id, i_enable_ex, i_enable_mem,
      input  i_cnt_clr,
      output o_pc_id, o_instr_id, o_valid_id,
      output o_pc_ex, o_instr_ex, o_valid_ex,
      output o_pc_mem, o_instr_mem, o_valid_mem,
      output o_pc_wb, o_instr_wb, o_valid_wb,
      output o_stall_cnt, o_flush_cnt, o_retire_cnt
   );

endinterface

// File: rtl/pipe_stage_reg.sv
// Single pipeline register: async reset, then synchronous clear, then load, else hold.
module pipe_stage_reg
   import pipe_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_reset,
   input  logic   i_clr_n,
   input  logic   i_en,
   input  stage_t i_d,
   output stage_t o_q
);

   stage_t q_reg;

   // Clear beats a low enable so a stalled stage can still be squashed.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         q_reg <= bubble();
      end else if (!i_clr_n) begin
         q_reg <= bubble();
      end else if (i_en) begin
         q_reg <= i_d;
      end
   end

   assign o_q = q_reg;

endmodule

// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX, EX/MEM, MEM/WB register bank with stall/flush/retire counters.
module pipe_stage_regs
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   pipe_stage_regs_if.slave  bus
);

   localparam int N_STAGES = 4;

   stage_t              if_src;
   stage_t              stage_d [N_STAGES];
   stage_t              stage_q [N_STAGES];
   logic [N_STAGES-1:0] clr_n;
   logic [N_STAGES-1:0] en;
   logic [2:0]          flush_add;
   logic                stall_inc;
   logic                retire_inc;

   logic [CNT_W-1:0]    stall_cnt_reg;
   logic [CNT_W-1:0]    flush_cnt_reg;
   logic [CNT_W-1:0]    retire_cnt_reg;

   // Index 0 = IF/ID ... 3 = MEM/WB.
   assign clr_n = {bus.i_reset_mem, bus.i_reset_ex, bus.i_reset_id, bus.i_reset_if};
   assign en    = {bus.i_enable_mem, bus.i_enable_ex, bus.i_enable_id, bus.i_enable_if};

   // A fetched word entering IF/ID is always a live instruction.
   always_comb begin
      if_src.pc    = bus.i_pc_if;
      if_src.instr = bus.i_instr_if;
      if_src.valid = 1'b1;
   end

   // Each stage loads from fetch (first) or from the stage before it.
   generate
      for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_src
            assign stage_d[gi] = if_src;
         end else begin : g_chain
            assign stage_d[gi] = stage_q[gi-1];
         end

         pipe_stage_reg u_reg (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_clr_n (clr_n[gi]),
            .i_en    (en[gi]),
            .i_d     (stage_d[gi]),
            .o_q     (stage_q[gi])
         );
      end
   endgenerate

   // Count live entries squashed by a clear this cycle (0..4).
   always_comb begin
      flush_add = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         if (!clr_n[i] && stage_q[i].valid) begin
            flush_add = flush_add + 3'd1;
         end
      end
   end

   // A stall is an IF/ID hold that is not also being cleared.
   assign stall_inc  = !bus.i_enable_if && bus.i_reset_if;
   // Retire only on an actual load of a valid entry into MEM/WB.
   assign retire_inc = bus.i_enable_mem && bus.i_reset_mem && stage_q[2].valid;

   // Performance counters; counter clear overrides same-cycle increments.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stall_cnt_reg  <= '0;
         flush_cnt_reg  <= '0;
         retire_cnt_reg <= '0;
      end else if (bus.i_cnt_clr) begin
         stall_cnt_reg  <= '0;
         flush_cnt_reg  <= '0;
         retire_cnt_reg <= '0;
      end else begin
         stall_cnt_reg  <= stall_cnt_reg + CNT_W'(stall_inc);
         flush_cnt_reg  <= flush_cnt_reg + CNT_W'(flush_add);
         retire_cnt_reg <= retire_cnt_reg + CNT_W'(retire_inc);
      end
   end

   assign bus.o_pc_id      = stage_q[0].pc;
   assign bus.o_instr_id   = stage_q[0].instr;
   assign bus.o_valid_id   = stage_q[0].valid;
   assign bus.o_pc_ex      = stage_q[1].pc;
   assign bus.o_instr_ex   = stage_q[1].instr;
   assign bus.o_valid_ex   = stage_q[1].valid;
   assign bus.o_pc_mem     = stage_q[2].pc;
   assign bus.o_instr_mem  = stage_q[2].instr;
   assign bus.o_valid_mem  = stage_q[2].valid;
   assign bus.o_pc_wb      = stage_q[3].pc;
   assign bus.o_instr_wb   = stage_q[3].instr;
   assign bus.o_valid_wb   = stage_q[3].valid;
   assign bus.o_stall_cnt  = stall_cnt_reg;
   assign bus.o_flush_cnt  = flush_cnt_reg;
   assign bus.o_retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed, table-driven bench for the pipeline register bank (4-bit counters).
module tb_pipe_stage_regs;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   pipe_stage_regs_if #(.CNT_W(4)) bus ();

   pipe_stage_regs #(.CNT_W(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc_in;
      logic [31:0] instr_in;
      logic [3:0]  en;       // bit0 IF/ID .. bit3 MEM/WB
      logic [3:0]  clr_n;
      logic [31:0] e_id;
      logic [31:0] e_ex;
      logic [31:0] e_mem;
      logic [31:0] e_wb;
      logic [3:0]  e_valid;  // bit0 id, bit1 ex, bit2 mem, bit3 wb
      logic [31:0] e_instr_ex;
      logic [3:0]  e_stall;
      logic [3:0]  e_flush;
      logic [3:0]  e_retire;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(logic [31:0] pc, logic [31:0] ins, logic [3:0] en,
                               logic [3:0] clr, logic [31:0] id, logic [31:0] ex,
                               logic [31:0] mem, logic [31:0] wb, logic [3:0] v,
                               logic [31:0] iex, logic [3:0] s, logic [3:0] f,
                               logic [3:0] r);
      vec_t t;
      t.pc_in = pc;   t.instr_in = ins; t.en = en;     t.clr_n = clr;
      t.e_id = id;    t.e_ex = ex;      t.e_mem = mem; t.e_wb = wb;
      t.e_valid = v;  t.e_instr_ex = iex;
      t.e_stall = s;  t.e_flush = f;    t.e_retire = r;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [3:0] en, input logic [3:0] clr, input logic cc);
      bus.i_pc_if      = pc;
      bus.i_instr_if   = ins;
      bus.i_enable_if  = en[0];
      bus.i_enable_id  = en[1];
      bus.i_enable_ex  = en[2];
      bus.i_enable_mem = en[3];
      bus.i_reset_if   = clr[0];
      bus.i_reset_id   = clr[1];
      bus.i_reset_ex   = clr[2];
      bus.i_reset_mem  = clr[3];
      bus.i_cnt_clr    = cc;
   endtask

   function automatic logic [31:0] vmask();
      return {28'd0, bus.o_valid_wb, bus.o_valid_mem, bus.o_valid_ex, bus.o_valid_id};
   endfunction

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      drive(32'h0, 32'h0, 4'hF, 4'hF, 1'b0);

      // free flow, data-hazard stall, control flush, clear with enable low
      vecs[0]  = mk(32'h00, 32'h1000_0000, 4'hF, 4'hF, 32'h00, 32'h00, 32'h00, 32'h00, 4'b0001, 32'h0000_0013, 4'd0, 4'd0, 4'd0);
      vecs[1]  = mk(32'h04, 32'h1000_0004, 4'hF, 4'hF, 32'h04, 32'h00, 32'h00, 32'h00, 4'b0011, 32'h1000_0000, 4'd0, 4'd0, 4'd0);
      vecs[2]  = mk(32'h08, 32'h1000_0008, 4'hF, 4'hF, 32'h08, 32'h04, 32'h00, 32'h00, 4'b0111, 32'h1000_0004, 4'd0, 4'd0, 4'd0);
      vecs[3]  = mk(32'h0C, 32'h1000_000C, 4'hF, 4'hF, 32'h0C, 32'h08, 32'h04, 32'h00, 4'b1111, 32'h1000_0008, 4'd0, 4'd0, 4'd1);
      vecs[4]  = mk(32'h10, 32'h1000_0010, 4'hF, 4'hF, 32'h10, 32'h0C, 32'h08, 32'h04, 4'b1111, 32'h1000_000C, 4'd0, 4'd0, 4'd2);
      vecs[5]  = mk(32'h14, 32'h1000_0014, 4'hF, 4'hF, 32'h14, 32'h10, 32'h0C, 32'h08, 4'b1111, 32'h1000_0010, 4'd0, 4'd0, 4'd3);
      vecs[6]  = mk(32'h18, 32'h0020_8133, 4'hF, 4'hF, 32'h18, 32'h14, 32'h10, 32'h0C, 4'b1111, 32'h1000_0014, 4'd0, 4'd0, 4'd4);
      vecs[7]  = mk(32'h1C, 32'h1000_001C, 4'hE, 4'hD, 32'h18, 32'h00, 32'h14, 32'h10, 4'b1101, 32'h0000_0013, 4'd1, 4'd1, 4'd5);
      vecs[8]  = mk(32'h1C, 32'h1000_001C, 4'hF, 4'hF, 32'h1C, 32'h18, 32'h00, 32'h14, 4'b1011, 32'h0020_8133, 4'd1, 4'd1, 4'd6);
      vecs[9]  = mk(32'h20, 32'h1000_0020, 4'hF, 4'hF, 32'h20, 32'h1C, 32'h18, 32'h00, 4'b0111, 32'h1000_001C, 4'd1, 4'd1, 4'd6);
      vecs[10] = mk(32'h24, 32'h1000_0024, 4'hF, 4'h8, 32'h00, 32'h00, 32'h00, 32'h18, 4'b1000, 32'h0000_0013, 4'd1, 4'd4, 4'd7);
      vecs[11] = mk(32'h28, 32'h1000_0028, 4'h7, 4'h7, 32'h28, 32'h00, 32'h00, 32'h00, 4'b0001, 32'h0000_0013, 4'd1, 4'd5, 4'd7);

      // Reset state is visible without any clock edge.
      #2;
      chk("rst_valid", vmask(), 32'h0);
      chk("rst_instr_id", bus.o_instr_id, 32'h0000_0013);
      chk("rst_instr_wb", bus.o_instr_wb, 32'h0000_0013);
      chk("rst_pc_wb", bus.o_pc_wb, 32'h0);
      chk("rst_retire", 32'(bus.o_retire_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].pc_in, vecs[i].instr_in, vecs[i].en, vecs[i].clr_n, 1'b0);
         step();
         $display("vec %0d: pc_in=%h en=%b clr_n=%b -> pc id/ex/mem/wb=%h/%h/%h/%h valid=%b",
                  i, vecs[i].pc_in, vecs[i].en, vecs[i].clr_n, bus.o_pc_id, bus.o_pc_ex,
                  bus.o_pc_mem, bus.o_pc_wb, vmask());
         chk($sformatf("v%0d_pc_id", i),  bus.o_pc_id,  vecs[i].e_id);
         chk($sformatf("v%0d_pc_ex", i),  bus.o_pc_ex,  vecs[i].e_ex);
         chk($sformatf("v%0d_pc_mem", i), bus.o_pc_mem, vecs[i].e_mem);
         chk($sformatf("v%0d_pc_wb", i),  bus.o_pc_wb,  vecs[i].e_wb);
         chk($sformatf("v%0d_valid", i),  vmask(), {28'd0, vecs[i].e_valid});
         chk($sformatf("v%0d_instr_ex", i), bus.o_instr_ex, vecs[i].e_instr_ex);
         chk($sformatf("v%0d_stall", i),  32'(bus.o_stall_cnt),  32'(vecs[i].e_stall));
         chk($sformatf("v%0d_flush", i),  32'(bus.o_flush_cnt),  32'(vecs[i].e_flush));
         chk($sformatf("v%0d_retire", i), 32'(bus.o_retire_cnt), 32'(vecs[i].e_retire));
      end

      // Counter clear, then 16 stalls wrap the 4-bit stall counter.
      drive(32'h2C, 32'h1000_002C, 4'hF, 4'hF, 1'b1);
      step();
      $display("cnt_clr: stall=%0d flush=%0d retire=%0d", bus.o_stall_cnt, bus.o_flush_cnt, bus.o_retire_cnt);
      chk("clr_stall", 32'(bus.o_stall_cnt), 32'h0);
      chk("clr_flush", 32'(bus.o_flush_cnt), 32'h0);
      chk("clr_retire", 32'(bus.o_retire_cnt), 32'h0);
      drive(32'h2C, 32'h1000_002C, 4'hE, 4'hF, 1'b0);
      for (int k = 0; k < 15; k++) step();
      $display("15 stalls: stall=%0d", bus.o_stall_cnt);
      chk("stall_15", 32'(bus.o_stall_cnt), 32'd15);
      step();
      $display("16 stalls: stall=%0d", bus.o_stall_cnt);
      chk("stall_wrap", 32'(bus.o_stall_cnt), 32'd0);
      step();
      chk("stall_after_wrap", 32'(bus.o_stall_cnt), 32'd1);
      drive(32'h2C, 32'h1000_002C, 4'hE, 4'hF, 1'b1);
      step();
      $display("stall+cnt_clr: stall=%0d", bus.o_stall_cnt);
      chk("stall_clr_override", 32'(bus.o_stall_cnt), 32'd0);

      // Fill all four stages, then assert async reset between edges.
      for (int k = 0; k < 4; k++) begin
         drive(32'h30 + 32'(4 * k), 32'h2000_0030 + 32'(4 * k), 4'hF, 4'hF, 1'b0);
         step();
      end
      $display("filled: pc_wb=%h valid=%b retire=%0d", bus.o_pc_wb, vmask(), bus.o_retire_cnt);
      chk("fill_valid", vmask(), 32'hF);
      chk("fill_pc_wb", bus.o_pc_wb, 32'h30);
      chk("fill_instr_wb", bus.o_instr_wb, 32'h2000_0030);
      #3;
      rst = 1'b1;
      #1;
      $display("async reset: valid=%b instr_ex=%h retire=%0d", vmask(), bus.o_instr_ex, bus.o_retire_cnt);
      chk("arst_valid", vmask(), 32'h0);
      chk("arst_instr_id", bus.o_instr_id, 32'h0000_0013);
      chk("arst_instr_ex", bus.o_instr_ex, 32'h0000_0013);
      chk("arst_instr_mem", bus.o_instr_mem, 32'h0000_0013);
      chk("arst_instr_wb", bus.o_instr_wb, 32'h0000_0013);
      chk("arst_retire", 32'(bus.o_retire_cnt), 32'h0);
      chk("arst_flush", 32'(bus.o_flush_cnt), 32'h0);
      #1;
      rst = 1'b0;
      drive(32'h40, 32'h2000_0040, 4'hF, 4'hF, 1'b0);
      step();
      $display("post reset: pc_id=%h valid=%b", bus.o_pc_id, vmask());
      chk("post_rst_pc_id", bus.o_pc_id, 32'h40);
      chk("post_rst_valid", vmask(), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
